// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive engine: state encoding, legal parameter ranges.
// Optional parity support is compiled in with UART_RX_PARITY_EN.
package uart_pkg;

    localparam int DATA_BITS_MIN  = 5;
    localparam int DATA_BITS_MAX  = 9;
    localparam int OVERSAMPLE_MIN = 8;
    localparam int OVERSAMPLE_MAX = 32;
    localparam int STOP_BITS_MIN  = 1;
    localparam int STOP_BITS_MAX  = 2;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
`ifdef UART_RX_PARITY_EN
        ST_PARITY    = 3'd3,
`endif
        ST_STOP      = 3'd4,
        ST_WAIT_IDLE = 3'd5
    } rx_state_e;

`ifdef UART_RX_PARITY_EN
    // High when data plus parity bit does not match the selected (odd/even) parity.
    function automatic logic parity_mismatch(input logic [DATA_BITS_MAX-1:0] data,
                                             input logic par_bit,
                                             input logic odd);
        return (^data) ^ par_bit ^ odd;
    endfunction
`endif

endpackage

// File: rtl/uart_rx_engine_if.sv
// Consumer-side bus of the UART receive engine: received word, handshake and status flags.
// parity_err exists only when UART_RX_PARITY_EN is defined.
interface uart_rx_engine_if #(parameter int DATA_BITS = 8);
    logic [DATA_BITS-1:0] data_out;
    logic                 data_valid;
    logic                 data_ack;
    logic                 busy_flag;
    logic                 done_flag;
    logic                 err_flag;
    logic                 overrun_flag;
`ifdef UART_RX_PARITY_EN
    logic                 parity_err;
`endif

    modport master (
        output data_out, data_valid, busy_flag, done_flag, err_flag, overrun_flag,
`ifdef UART_RX_PARITY_EN
        output parity_err,
`endif
        input  data_ack
    );

    modport slave (
        input  data_out, data_valid, busy_flag, done_flag, err_flag, overrun_flag,
`ifdef UART_RX_PARITY_EN
        input  parity_err,
`endif
        output data_ack
    );
endinterface

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-cycle pulse every max(baud_div,1) clocks,
// phase restarted by the receiver when it detects a start edge.
module uart_baud_tick #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rx_arst_n,
    input  logic             srst,
    input  logic             restart,
    input  logic [DIV_W-1:0] baud_div,
    output logic             tick
);

    logic [DIV_W-1:0] cnt_r;
    logic [DIV_W-1:0] div_m1_s;
    logic             tick_r;

    assign div_m1_s = (baud_div == {DIV_W{1'b0}}) ? {DIV_W{1'b0}} : (baud_div - DIV_W'(1));
    assign tick     = tick_r;

    // Divider counter; >= keeps it bounded if baud_div shrinks mid-count.
    always_ff @(posedge clk or negedge rx_arst_n) begin
        if (!rx_arst_n) begin
            cnt_r  <= {DIV_W{1'b0}};
            tick_r <= 1'b0;
        end else if (srst || restart) begin
            cnt_r  <= {DIV_W{1'b0}};
            tick_r <= 1'b0;
        end else if (cnt_r >= div_m1_s) begin
            cnt_r  <= {DIV_W{1'b0}};
            tick_r <= 1'b1;
        end else begin
            cnt_r  <= cnt_r + DIV_W'(1);
            tick_r <= 1'b0;
        end
    end

endmodule

// File: rtl/uart_rx_engine.sv
// UART receive engine: synchroniser, frame FSM, shift register and output buffer.
// Define UART_RX_PARITY_EN to add a parity bit (parity_odd input, parity_err pulse).
module uart_rx_engine
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int STOP_BITS  = 1,
    parameter int DIV_W      = 16
) (
    input  logic             clk,
    input  logic             rx_arst_n,
    input  logic             rx_rst,
    input  logic             rx_en,
    input  logic             rx,
    input  logic [DIV_W-1:0] baud_div,
`ifdef UART_RX_PARITY_EN
    input  logic             parity_odd,
`endif
    uart_rx_engine_if.master rx_bus
);

    localparam int OS_W = $clog2(OVERSAMPLE);
    localparam int BC_W = $clog2(DATA_BITS + 1);
    localparam logic [OS_W-1:0] OS_HALF_M1 = OS_W'(OVERSAMPLE / 2 - 1);
    localparam logic [OS_W-1:0] OS_FULL_M1 = OS_W'(OVERSAMPLE - 1);
    localparam logic [BC_W-1:0] BIT_LAST   = BC_W'(DATA_BITS - 1);
    localparam logic            STOP_LAST  = 1'(STOP_BITS - 1);

    rx_state_e            state_r, state_nxt_s;
    logic                 sync1_r, sync2_r, rx_prev_r;
    logic [OS_W-1:0]      os_cnt_r;
    logic [BC_W-1:0]      bit_cnt_r;
    logic                 stop_cnt_r;
    logic [DATA_BITS-1:0] shift_r, data_out_r;
    logic                 data_valid_r, done_r, err_r, overrun_r;
    logic                 tick_s, rx_fall_s, os_half_s, os_full_s, good_s;
    logic                 os_clr_s, shift_en_s, stop_inc_s, cnt_clr_s;
    logic                 commit_s, frame_err_s, restart_s;
`ifdef UART_RX_PARITY_EN
    logic                 par_bad_r, perr_r, par_en_s, perr_s;
`endif

    uart_baud_tick #(.DIV_W(DIV_W)) u_baud_tick (
        .clk       (clk),
        .rx_arst_n (rx_arst_n),
        .srst      (rx_rst),
        .restart   (restart_s),
        .baud_div  (baud_div),
        .tick      (tick_s)
    );

    assign rx_fall_s = rx_prev_r & ~sync2_r;
    assign os_half_s = tick_s && (os_cnt_r == OS_HALF_M1);
    assign os_full_s = tick_s && (os_cnt_r == OS_FULL_M1);
`ifdef UART_RX_PARITY_EN
    assign good_s    = commit_s && !par_bad_r;
`else
    assign good_s    = commit_s;
`endif

    // FSM state register.
    always_ff @(posedge clk or negedge rx_arst_n) begin
        if (!rx_arst_n)  state_r <= ST_IDLE;
        else if (rx_rst) state_r <= ST_IDLE;
        else             state_r <= state_nxt_s;
    end

    // Next-state and per-cycle control decode; rx_en low aborts any frame.
    always_comb begin
        state_nxt_s = state_r;
        os_clr_s    = 1'b0;
        shift_en_s  = 1'b0;
        stop_inc_s  = 1'b0;
        cnt_clr_s   = 1'b0;
        commit_s    = 1'b0;
        frame_err_s = 1'b0;
        restart_s   = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_en_s    = 1'b0;
        perr_s      = 1'b0;
`endif
        case (state_r)
            ST_IDLE: begin
                os_clr_s  = 1'b1;
                cnt_clr_s = 1'b1;
                if (rx_en && rx_fall_s) begin
                    restart_s   = 1'b1;
                    state_nxt_s = ST_START;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (!rx_en) begin
                    state_nxt_s = ST_IDLE;
                end else if (os_half_s) begin
                    os_clr_s    = 1'b1;
                    state_nxt_s = sync2_r ? ST_IDLE : ST_DATA;
                end else begin
                    state_nxt_s = ST_START;
                end
            end
            ST_DATA: begin
                if (!rx_en) begin
                    state_nxt_s = ST_IDLE;
                end else if (os_full_s) begin
                    os_clr_s   = 1'b1;
                    shift_en_s = 1'b1;
                    if (bit_cnt_r == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                        state_nxt_s = ST_PARITY;
`else
                        state_nxt_s = ST_STOP;
`endif
                    end else begin
                        state_nxt_s = ST_DATA;
                    end
                end else begin
                    state_nxt_s = ST_DATA;
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (!rx_en) begin
                    state_nxt_s = ST_IDLE;
                end else if (os_full_s) begin
                    os_clr_s    = 1'b1;
                    par_en_s    = 1'b1;
                    perr_s      = parity_mismatch(DATA_BITS_MAX'(shift_r), sync2_r, parity_odd);
                    state_nxt_s = ST_STOP;
                end else begin
                    state_nxt_s = ST_PARITY;
                end
            end
`endif
            ST_STOP: begin
                if (!rx_en) begin
                    state_nxt_s = ST_IDLE;
                end else if (os_full_s) begin
                    os_clr_s = 1'b1;
                    if (!sync2_r) begin
                        frame_err_s = 1'b1;
                        state_nxt_s = ST_WAIT_IDLE;
                    end else if (stop_cnt_r == STOP_LAST) begin
                        commit_s    = 1'b1;
                        state_nxt_s = ST_IDLE;
                    end else begin
                        stop_inc_s  = 1'b1;
                        state_nxt_s = ST_STOP;
                    end
                end else begin
                    state_nxt_s = ST_STOP;
                end
            end
            ST_WAIT_IDLE: begin
                if (!rx_en || sync2_r) state_nxt_s = ST_IDLE;
                else                   state_nxt_s = ST_WAIT_IDLE;
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Line synchroniser, counters and shift register.
    always_ff @(posedge clk or negedge rx_arst_n) begin
        if (!rx_arst_n || rx_rst) begin
            if (!rx_arst_n || rx_rst) begin
                sync1_r    <= 1'b1;
                sync2_r    <= 1'b1;
                rx_prev_r  <= 1'b1;
                os_cnt_r   <= {OS_W{1'b0}};
                bit_cnt_r  <= {BC_W{1'b0}};
                stop_cnt_r <= 1'b0;
                shift_r    <= {DATA_BITS{1'b0}};
            end
        end else begin
            sync1_r   <= rx;
            sync2_r   <= sync1_r;
            rx_prev_r <= sync2_r;
            if (os_clr_s)    os_cnt_r <= {OS_W{1'b0}};
            else if (tick_s) os_cnt_r <= os_cnt_r + OS_W'(1);
            if (cnt_clr_s)       bit_cnt_r <= {BC_W{1'b0}};
            else if (shift_en_s) bit_cnt_r <= bit_cnt_r + BC_W'(1);
            if (cnt_clr_s)       stop_cnt_r <= 1'b0;
            else if (stop_inc_s) stop_cnt_r <= 1'b1;
            if (shift_en_s) shift_r <= {sync2_r, shift_r[DATA_BITS-1:1]};
        end
    end

    // Output buffer and flags; a word landing with data_ack set stays valid, no overrun.
    always_ff @(posedge clk or negedge rx_arst_n) begin
        if (!rx_arst_n || rx_rst) begin
            if (!rx_arst_n || rx_rst) begin
                data_out_r   <= {DATA_BITS{1'b0}};
                data_valid_r <= 1'b0;
                done_r       <= 1'b0;
                err_r        <= 1'b0;
                overrun_r    <= 1'b0;
            end
        end else begin
            done_r <= good_s;
            err_r  <= frame_err_s;
            if (good_s) begin
                data_out_r   <= shift_r;
                data_valid_r <= 1'b1;
                if (data_valid_r && !rx_bus.data_ack) overrun_r <= 1'b1;
            end else if (rx_bus.data_ack) begin
                data_valid_r <= 1'b0;
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    // Parity verdict for the current frame and its error pulse.
    always_ff @(posedge clk or negedge rx_arst_n) begin
        if (!rx_arst_n) begin
            par_bad_r <= 1'b0;
            perr_r    <= 1'b0;
        end else if (rx_rst || cnt_clr_s) begin
            par_bad_r <= 1'b0;
            perr_r    <= 1'b0;
        end else begin
            if (par_en_s) par_bad_r <= perr_s;
            perr_r <= perr_s;
        end
    end
    assign rx_bus.parity_err = perr_r;
`endif

    assign rx_bus.data_out     = data_out_r;
    assign rx_bus.data_valid   = data_valid_r;
    assign rx_bus.busy_flag    = (state_r != ST_IDLE);
    assign rx_bus.done_flag    = done_r;
    assign rx_bus.err_flag     = err_r;
    assign rx_bus.overrun_flag = overrun_r;

endmodule

// File: tb/tb_uart_rx_engine.sv
// Scoreboard bench for uart_rx_engine at DATA_BITS=8, OVERSAMPLE=16, baud_div=4 (64 clk/bit).
// Covers parity frames too when UART_RX_PARITY_EN is defined.
module tb_uart_rx_engine;

    localparam int BIT_CLK = 64;
`ifdef UART_RX_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rx_arst_n = 1'b0;
    logic        rx_rst = 1'b0;
    logic        rx_en = 1'b1;
    logic        rx = 1'b1;
    logic [15:0] baud_div = 16'd4;
`ifdef UART_RX_PARITY_EN
    logic        parity_odd = 1'b0;
    int          n_perr = 0;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int n_done = 0;
    int n_err = 0;
    int n_pushed = 0;
    logic [7:0] exp_q[$];

    uart_rx_engine_if #(.DATA_BITS(8)) bus ();

    uart_rx_engine #(.DATA_BITS(8), .OVERSAMPLE(16), .STOP_BITS(1), .DIV_W(16)) dut (
        .clk       (clk),
        .rx_arst_n (rx_arst_n),
        .rx_rst    (rx_rst),
        .rx_en     (rx_en),
        .rx        (rx),
        .baud_div  (baud_div),
`ifdef UART_RX_PARITY_EN
        .parity_odd(parity_odd),
`endif
        .rx_bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every done pulse must match the oldest expected word.
    always @(negedge clk) begin
        if (bus.done_flag) begin
            n_done++;
            if (exp_q.size() == 0) check_eq("done_unexpected", 32'(exp_q.size()), 32'd1);
            else                   check_eq("rx_data", 32'(bus.data_out), 32'(exp_q.pop_front()));
        end
        if (bus.err_flag) n_err++;
`ifdef UART_RX_PARITY_EN
        if (bus.parity_err) n_perr++;
`endif
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_word(input logic [7:0] d);
        exp_q.push_back(d);
        n_pushed++;
    endtask

    // cut_kind: 0 none, 1 drop rx_en at bit cut_bit, 2 pulse rx_arst_n at bit cut_bit.
    task automatic send_frame(input logic [7:0] d, input logic stop_v, input logic par_v,
                              input int cut_bit, input int cut_kind);
        logic [10:0] fv;
        fv = {stop_v, par_v, d, 1'b0};
        for (int i = 0; i < 11; i++) begin
            if (!(i == 9 && !PAR)) begin
                rx = fv[i];
                if (i == cut_bit && cut_kind == 1) begin
                    wait_clk(1);
                    rx_en = 1'b0;
                    wait_clk(2);
                    check_eq("abort_busy", 32'(bus.busy_flag), 32'd0);
                end else if (i == cut_bit && cut_kind == 2) begin
                    wait_clk(1);
                    rx_arst_n = 1'b0;
                    wait_clk(1);
                    check_eq("rst_data_out", 32'(bus.data_out), 32'd0);
                    check_eq("rst_valid", 32'(bus.data_valid), 32'd0);
                    check_eq("rst_busy", 32'(bus.busy_flag), 32'd0);
                    check_eq("rst_flags", 32'({bus.done_flag, bus.err_flag, bus.overrun_flag}), 32'd0);
                    wait_clk(4);
                    rx_arst_n = 1'b1;
                end
                wait_clk(BIT_CLK);
            end
        end
    endtask

    task automatic ack_word();
        bus.data_ack = 1'b1;
        wait_clk(1);
        bus.data_ack = 1'b0;
        wait_clk(1);
    endtask

    initial begin
        bus.data_ack = 1'b0;
        wait_clk(5);
        check_eq("reset_data_out", 32'(bus.data_out), 32'd0);
        check_eq("reset_flags", 32'({bus.data_valid, bus.busy_flag, bus.done_flag,
                                      bus.err_flag, bus.overrun_flag}), 32'd0);
        rx_arst_n = 1'b1;
        wait_clk(10);

        // Good frame 0x55.
        expect_word(8'h55);
        send_frame(8'h55, 1'b1, 1'b0, -1, 0);
        wait_clk(16);
        check_eq("f55_valid", 32'(bus.data_valid), 32'd1);
        check_eq("f55_done_cnt", 32'(n_done), 32'd1);
        check_eq("f55_err_cnt", 32'(n_err), 32'd0);
        ack_word();
        check_eq("ack_clears_valid", 32'(bus.data_valid), 32'd0);

        // 20-clk glitch on the line.
        rx = 1'b0;
        wait_clk(15);
        check_eq("glitch_busy", 32'(bus.busy_flag), 32'd1);
        wait_clk(5);
        rx = 1'b1;
        wait_clk(100);
        check_eq("glitch_idle", 32'(bus.busy_flag), 32'd0);
        check_eq("glitch_no_flags", 32'(n_done + n_err), 32'd1);
        check_eq("glitch_valid", 32'(bus.data_valid), 32'd0);

        // Framing error on 0xA3, line held low after stop.
        send_frame(8'hA3, 1'b0, 1'b0, -1, 0);
        wait_clk(16);
        check_eq("ferr_pulse", 32'(n_err), 32'd1);
        check_eq("ferr_wait_idle", 32'(bus.busy_flag), 32'd1);
        check_eq("ferr_valid", 32'(bus.data_valid), 32'd0);
        rx = 1'b1;
        wait_clk(8);
        check_eq("ferr_back_idle", 32'(bus.busy_flag), 32'd0);

        // Overrun: two words without data_ack.
        expect_word(8'h11);
        send_frame(8'h11, 1'b1, 1'b0, -1, 0);
        expect_word(8'h22);
        send_frame(8'h22, 1'b1, 1'b0, -1, 0);
        wait_clk(16);
        check_eq("ovr_data", 32'(bus.data_out), 32'h22);
        check_eq("ovr_flag", 32'(bus.overrun_flag), 32'd1);
        ack_word();
        check_eq("ovr_ack_valid", 32'(bus.data_valid), 32'd0);
        check_eq("ovr_sticky", 32'(bus.overrun_flag), 32'd1);

        // rx_en dropped mid-frame.
        send_frame(8'h5A, 1'b1, 1'b0, 3, 1);
        rx_en = 1'b1;
        wait_clk(16);
        check_eq("abort_data_kept", 32'(bus.data_out), 32'h22);
        check_eq("abort_no_done", 32'(n_done), 32'd3);

        // Synchronous clear.
        rx_rst = 1'b1;
        wait_clk(1);
        rx_rst = 1'b0;
        wait_clk(1);
        check_eq("srst_overrun", 32'(bus.overrun_flag), 32'd0);
        check_eq("srst_data_out", 32'(bus.data_out), 32'd0);

        // Async reset during data bit 4 of 0xFF, then 0x3C.
        send_frame(8'hFF, 1'b1, 1'b1, 5, 2);
        wait_clk(16);
        check_eq("post_rst_valid", 32'(bus.data_valid), 32'd0);
        expect_word(8'h3C);
        send_frame(8'h3C, 1'b1, 1'b0, -1, 0);
        wait_clk(16);
        check_eq("post_rst_data", 32'(bus.data_out), 32'h3C);
        check_eq("post_rst_valid2", 32'(bus.data_valid), 32'd1);
        ack_word();

`ifdef UART_RX_PARITY_EN
        parity_odd = 1'b0;
        send_frame(8'h07, 1'b1, 1'b0, -1, 0);
        wait_clk(16);
        check_eq("par_err_pulse", 32'(n_perr), 32'd1);
        check_eq("par_err_no_valid", 32'(bus.data_valid), 32'd0);
        expect_word(8'h07);
        send_frame(8'h07, 1'b1, 1'b1, -1, 0);
        wait_clk(16);
        check_eq("par_ok_valid", 32'(bus.data_valid), 32'd1);
        check_eq("par_ok_no_err", 32'(n_perr), 32'd1);
`endif

        check_eq("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        check_eq("done_total", 32'(n_done), 32'(n_pushed));
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_engine.md
UART_RX_ENGINE -- requirements
Module: uart_rx_engine

Interface
REQ-001 Parameter DATA_BITS, 8, data bits per frame, legal 5..9.
REQ-002 Parameter OVERSAMPLE, 16, oversample ticks per bit, even, legal 8..32.
REQ-003 Parameter STOP_BITS, 1, stop bits checked per frame, legal 1 or 2.
REQ-004 Parameter DIV_W, 16, width of baud_div.
REQ-005 Port clk  input  1  clock; all logic rising-edge.
REQ-006 Port rx_arst_n  input  1  reset, asynchronous, active-low.
REQ-007 Port rx_rst  input  1  synchronous clear, active-high.
REQ-008 Port rx_en  input  1  receiver enable.
REQ-009 Port rx  input  1  asynchronous serial line, idle high.
REQ-010 Port baud_div  input  DIV_W  clk cycles per oversample tick; 0 treated as 1.
REQ-011 Port data_ack  input  1  consumer accepts data_out.
REQ-012 Port data_out  output  DATA_BITS  received word, LSB first on line.
REQ-013 Port data_valid  output  1  data_out holds an unaccepted word.
REQ-014 Port busy_flag  output  1  frame in progress (state not IDLE).
REQ-015 Port done_flag  output  1  one-cycle pulse per good frame.
REQ-016 Port err_flag  output  1  one-cycle pulse on framing error.
REQ-017 Port overrun_flag  output  1  sticky; good frame completed while data_valid high.

Function
REQ-018 rx SHALL pass a 2-flop synchroniser; all decisions use the synchronised value.
REQ-019 Tick generator SHALL pulse once every max(baud_div,1) cycles and SHALL restart its count on start-edge detection.
REQ-020 FSM states SHALL be IDLE, START, DATA, PARITY (macro only), STOP, WAIT_IDLE.
REQ-021 IDLE: synchronised-rx falling edge with rx_en high SHALL enter START; otherwise remain.
REQ-022 START: at tick OVERSAMPLE/2, rx high SHALL return to IDLE with no flag (glitch reject); rx low SHALL enter DATA.
REQ-023 DATA: each bit sampled once at OVERSAMPLE ticks after previous sample; after DATA_BITS samples SHALL enter PARITY or STOP.
REQ-024 STOP: each of STOP_BITS sampled at mid-bit; any 0 SHALL pulse err_flag, discard word, enter WAIT_IDLE.
REQ-025 WAIT_IDLE SHALL return to IDLE on first synchronised rx high.
REQ-026 Good frame: the cycle after the last stop sample, data_out loads, data_valid sets, done_flag pulses, state returns to IDLE.
REQ-027 data_valid SHALL clear on data_ack; new word and data_ack in the same cycle SHALL leave data_valid high with no overrun.
REQ-028 Good frame while data_valid high and no data_ack SHALL overwrite data_out and set overrun_flag until reset or rx_rst.
REQ-029 rx_en low mid-frame SHALL abort to IDLE next cycle, no flags, data_out unchanged.

Reset
REQ-030 rx_arst_n low or rx_rst high SHALL force IDLE, counters 0, data_out 0, all flags 0, synchroniser to 1.
REQ-031 Reset mid-frame SHALL discard the partial word; the first frame after release SHALL be received normally.

Configuration
REQ-032 With UART_RX_PARITY_EN defined: input parity_odd (1 bit) and output parity_err (1-cycle pulse) SHALL exist; PARITY samples one bit after data; mismatch SHALL pulse parity_err and discard the word (no data_valid), then continue to STOP.
REQ-033 Without UART_RX_PARITY_EN: no PARITY state, no parity ports; frame = start + DATA_BITS + STOP_BITS.

Structure
REQ-034 Package uart_pkg SHALL hold the state encoding and legal-range constants for DATA_BITS, OVERSAMPLE and STOP_BITS.
REQ-035 Sub-module uart_baud_tick SHALL implement the tick generator; FSM, shift register and output buffer stay in uart_rx_engine.

Verification (DATA_BITS=8, OVERSAMPLE=16, baud_div=4, 64 clk/bit)
REQ-036 Frame 0x55 with stop=1 -> data_out=0x55, data_valid=1, done_flag one pulse, err_flag=0.
REQ-037 rx low for 20 clk then high -> state back to IDLE, no flags, data_valid unchanged.
REQ-038 Frame 0xA3 with stop=0 -> err_flag one pulse, data_valid stays 0, then IDLE after rx returns high.
REQ-039 Frames 0x11 then 0x22 without data_ack -> data_out=0x22, overrun_flag=1; data_ack then clears data_valid.
REQ-040 UART_RX_PARITY_EN, parity_odd=0, frame 0x07 with parity bit 0 -> parity_err pulse, no data_valid.
REQ-041 rx_arst_n pulsed low during bit 4 of 0xFF, then 0x3C sent -> all outputs 0 in reset, then data_out=0x3C.
